// File: rtl/mux_rr_n.sv
// N-channel valid/ready multiplexer with direct, fixed-priority and round-robin
// selection feeding a single registered output stage.
module mux_rr_n #(
    parameter int N = 3,
    parameter int W = 8,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      mode,
    input  logic [CW-1:0]   sel,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [N*W-1:0]  in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic [CW-1:0]   out_chan
);

    logic          load;
    logic          grant_vld;
    logic [CW-1:0] grant;
    logic [CW-1:0] ptr;
    logic [W-1:0]  grant_data;

    assign load = !out_valid || out_ready;

    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        case (mode)
            2'd0: begin
                for (int i = 0; i < N; i++) begin
                    if (int'(sel) == i && in_valid[i]) begin
                        grant_vld = 1'b1;
                        grant     = CW'(i);
                    end
                end
            end
            2'd2: begin
                // Lowest valid index overall covers the wrap case; any valid
                // index above ptr then overrides it, lowest such one winning.
                for (int i = N - 1; i >= 0; i--) begin
                    if (in_valid[i]) begin
                        grant_vld = 1'b1;
                        grant     = CW'(i);
                    end
                end
                for (int i = N - 1; i >= 0; i--) begin
                    if (in_valid[i] && i > int'(ptr)) begin
                        grant = CW'(i);
                    end
                end
            end
            default: begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (in_valid[i]) begin
                        grant_vld = 1'b1;
                        grant     = CW'(i);
                    end
                end
            end
        endcase
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == CW'(i)) begin
                grant_data = in_data[i*W +: W];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_n && load && grant_vld) begin
            for (int i = 0; i < N; i++) begin
                if (grant == CW'(i)) begin
                    in_ready[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= CW'(N - 1);
        end else if (load) begin
            out_valid <= grant_vld;
            if (grant_vld) begin
                out_data <= grant_data;
                out_chan <= grant;
                if (mode == 2'd2) begin
                    ptr <= grant;
                end
            end
        end
    end

endmodule
